axi_read_scheduler: RTL and testbench

- Round-robin scheduler that shares one AXI read channel (AR + R) among READ_MASTERS cache-side requesters: I-cache, D-cache and the instruction stream buffer.
- Sits between the cache read ports and the AXI read pins.
- Issues one burst at a time, tags ARID with the master index, and steers R beats back to the granted master.
- Flags protocol violations (foreign RID, short or long burst) in sticky error bits.

---
 rtl/axi_read_scheduler.sv | 168 ++++++++++++++++
 tb/tb_axi_read_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_scheduler.sv
//============================================================================
// Module      : axi_read_scheduler
// Description : Round-robin sharing of one AXI read channel among cache-side
//               masters, with ID tagging, R-beat steering and sticky errors.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module axi_read_scheduler #(
   parameter int READ_MASTERS = 3,
   parameter int ADDR_WIDTH   = 26,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [READ_MASTERS-1:0]            m_arvalid,
   input  logic [READ_MASTERS*ADDR_WIDTH-1:0] m_araddr,
   input  logic [READ_MASTERS*4-1:0]          m_arlen,
   output logic [READ_MASTERS-1:0]            m_arready,
   output logic [READ_MASTERS-1:0]            m_rvalid,
   output logic                               m_rlast,
   output logic [DATA_WIDTH-1:0]              m_rdata,
   input  logic [READ_MASTERS-1:0]            m_rready,
   output logic                               ARVALID,
   input  logic                               ARREADY,
   output logic [3:0]                         ARID,
   output logic [3:0]                         ARLEN,
   output logic [ADDR_WIDTH-1:0]              ARADDR,
   input  logic                               RVALID,
   output logic                               RREADY,
   input  logic                               RLAST,
   input  logic [3:0]                         RID,
   input  logic [DATA_WIDTH-1:0]              RDATA,
   output logic                               busy,
   output logic                               err_id,
   output logic                               err_len
);

   localparam int GW = (READ_MASTERS > 1) ? $clog2(READ_MASTERS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            len_q, len_d;
   logic [3:0]            beat_q, beat_d;
   logic                  err_id_q, err_id_d;
   logic                  err_len_q, err_len_d;

   logic                  arb_found;
   logic [GW-1:0]         arb_pick;
   int                    arb_idx;
   logic [3:0]            arid_w;
   logic                  rid_match_w;
   logic                  beat_xfer_w;

   // First requester at or after rr_ptr, wrapping modulo READ_MASTERS.
   always_comb begin
      arb_found = 1'b0;
      arb_pick  = '0;
      arb_idx   = 0;
      for (int k = 0; k < READ_MASTERS; k++) begin
         arb_idx = int'(rr_ptr_q) + k;
         if (arb_idx >= READ_MASTERS) arb_idx = arb_idx - READ_MASTERS;
         if (!arb_found && m_arvalid[arb_idx]) begin
            arb_found = 1'b1;
            arb_pick  = arb_idx[GW-1:0];
         end
      end
   end

   assign arid_w      = {{(4-GW){1'b0}}, grant_q};
   assign rid_match_w = (RID == arid_w);

   assign ARVALID = (state_q == S_ADDR);
   assign ARADDR  = addr_q;
   assign ARLEN   = len_q;
   assign ARID    = arid_w;
   // Foreign-ID beats are always drained so they cannot block the channel.
   assign RREADY  = (state_q == S_DATA) && (rid_match_w ? m_rready[grant_q] : 1'b1);
   assign m_rdata = RDATA;
   assign m_rlast = RLAST;
   assign busy    = (state_q != S_IDLE);
   assign err_id  = err_id_q;
   assign err_len = err_len_q;

   assign beat_xfer_w = (state_q == S_DATA) && RVALID && RREADY;

   for (genvar i = 0; i < READ_MASTERS; i++) begin : g_master
      assign m_arready[i] = (state_q == S_ADDR) && ARREADY && (grant_q == GW'(i));
      assign m_rvalid[i]  = (state_q == S_DATA) && RVALID && rid_match_w && (grant_q == GW'(i));
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      len_d     = len_q;
      beat_d    = beat_q;
      err_id_d  = err_id_q;
      err_len_d = err_len_q;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               grant_d = arb_pick;
               addr_d  = m_araddr[arb_pick*ADDR_WIDTH +: ADDR_WIDTH];
               len_d   = m_arlen[arb_pick*4 +: 4];
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (ARREADY) begin
               beat_d  = 4'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (beat_xfer_w) begin
               if (!rid_match_w) begin
                  err_id_d = 1'b1;
               end else begin
                  beat_d = beat_q + 4'd1;
                  if (RLAST) begin
                     if (beat_q != len_q) err_len_d = 1'b1;
                     rr_ptr_d = (grant_q == GW'(READ_MASTERS - 1)) ? '0 : grant_q + GW'(1);
                     state_d  = S_IDLE;
                  end else if (beat_q == len_q) begin
                     err_len_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         err_id_q  <= 1'b0;
         err_len_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         err_id_q  <= err_id_d;
         err_len_q <= err_len_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_read_scheduler.sv
//============================================================================
// Module      : tb_axi_read_scheduler
// Description : Directed scoreboard bench for axi_read_scheduler.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_axi_read_scheduler;

   localparam int RM = 3;
   localparam int AW = 26;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [RM-1:0]    m_arvalid = '0;
   logic [RM*AW-1:0] m_araddr = '0;
   logic [RM*4-1:0]  m_arlen = '0;
   logic [RM-1:0]    m_arready;
   logic [RM-1:0]    m_rvalid;
   logic             m_rlast;
   logic [DW-1:0]    m_rdata;
   logic [RM-1:0]    m_rready = '1;
   logic             ARVALID;
   logic             ARREADY = 1'b1;
   logic [3:0]       ARID;
   logic [3:0]       ARLEN;
   logic [AW-1:0]    ARADDR;
   logic             RVALID = 1'b0;
   logic             RREADY;
   logic             RLAST = 1'b0;
   logic [3:0]       RID = '0;
   logic [DW-1:0]    RDATA = '0;
   logic             busy;
   logic             err_id;
   logic             err_len;

   axi_read_scheduler #(.READ_MASTERS(RM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
      .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata), .m_rready(m_rready),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
      .busy(busy), .err_id(err_id), .err_len(err_len)
   );

   always #5 clk = ~clk;

   typedef struct { logic [3:0] id; logic [3:0] len; logic [AW-1:0] addr; } ar_exp_t;
   typedef struct { int master; logic [DW-1:0] data; logic last; } r_exp_t;

   ar_exp_t arq[$];
   r_exp_t  rq[$];
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected AR/R entries whenever the DUT completes a handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (ARVALID && ARREADY) begin
            if (arq.size() == 0) check("ar_unexpected", 1, 0);
            else begin
               ar_exp_t e;
               e = arq.pop_front();
               check("arid", 64'(ARID), 64'(e.id));
               check("arlen", 64'(ARLEN), 64'(e.len));
               check("araddr", 64'(ARADDR), 64'(e.addr));
               check("m_arready", 64'(m_arready), 64'(1 << e.id));
            end
         end else begin
            check("m_arready_idle", 64'(m_arready), 0);
         end
         if ((m_rvalid & m_rready) != '0) begin
            if (rq.size() == 0) check("r_unexpected", 64'(m_rvalid), 0);
            else begin
               r_exp_t r;
               r = rq.pop_front();
               check("m_rvalid", 64'(m_rvalid), 64'(1 << r.master));
               check("m_rdata", 64'(m_rdata), 64'(r.data));
               check("m_rlast", 64'(m_rlast), 64'(r.last));
            end
         end
      end
   end

   task automatic set_req(input int m, input logic [AW-1:0] addr, input logic [3:0] len);
      ar_exp_t e;
      m_arvalid[m] = 1'b1;
      m_araddr[m*AW +: AW] = addr;
      m_arlen[m*4 +: 4] = len;
      e.id = 4'(m); e.len = len; e.addr = addr;
      arq.push_back(e);
   endtask

   task automatic wait_arready(input int m);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_arready[m] && n < 40);
      if (!m_arready[m]) check("arready_timeout", 0, 1);
      @(posedge clk); #1;
      m_arvalid[m] = 1'b0;
   endtask

   task automatic beat(input logic [3:0] rid, input logic [DW-1:0] data, input logic last,
                       input int deliver_to);
      int n = 0;
      if (deliver_to >= 0) begin
         r_exp_t r;
         r.master = deliver_to; r.data = data; r.last = last;
         rq.push_back(r);
      end
      RVALID = 1'b1; RID = rid; RDATA = data; RLAST = last;
      do begin
         @(negedge clk);
         n++;
      end while (!RREADY && n < 40);
      if (!RREADY) check("rready_timeout", 0, 1);
      @(posedge clk); #1;
      RVALID = 1'b0; RLAST = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_arvalid", 64'(ARVALID), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_rready", 64'(RREADY), 0);
      check("rst_errs", 64'({err_id, err_len}), 0);
      check("rst_m_arready", 64'(m_arready), 0);
      #12 rst = 1'b0;
      @(posedge clk); #1;

      // All three together, len 0: two rounds 0,1,2.
      for (int round = 0; round < 2; round++) begin
         for (int m = 0; m < RM; m++) set_req(m, AW'(32'h10 * (m + 1) + round), 4'd0);
         for (int m = 0; m < RM; m++) begin
            wait_arready(m);
            beat(4'(m), 32'hB0 + 32'(round * 16 + m), 1'b1, m);
         end
      end

      // Single request to master 0, len 3.
      set_req(0, 26'h0000100, 4'd3);
      wait_arready(0);
      for (int b = 0; b < 4; b++) beat(4'd0, 32'hA0 + 32'(b), (b == 3), 0);
      check("single_busy_low", 64'(busy), 0);
      check("single_errs", 64'({err_id, err_len}), 0);

      // rr_ptr now 1: masters 0 and 1 together -> 1 wins first.
      set_req(0, 26'h0000200, 4'd0);
      set_req(1, 26'h0000300, 4'd0);
      arq.delete();
      begin
         ar_exp_t e;
         e.id = 4'd1; e.len = 4'd0; e.addr = 26'h0000300; arq.push_back(e);
         e.id = 4'd0; e.len = 4'd0; e.addr = 26'h0000200; arq.push_back(e);
      end
      wait_arready(1);
      beat(4'd1, 32'hC1, 1'b1, 1);
      wait_arready(0);
      beat(4'd0, 32'hC0, 1'b1, 0);

      // Address backpressure then data backpressure on master 1.
      ARREADY = 1'b0;
      set_req(1, 26'h1234560, 4'd3);
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_arvalid", 64'(ARVALID), 1);
         check("stall_araddr", 64'(ARADDR), 64'h1234560);
      end
      @(posedge clk); #1;
      ARREADY = 1'b1;
      wait_arready(1);
      beat(4'd1, 32'hD0, 1'b0, 1);
      begin
         r_exp_t r;
         r.master = 1; r.data = 32'hD1; r.last = 1'b0;
         rq.push_back(r);
      end
      m_rready[1] = 1'b0;
      RVALID = 1'b1; RID = 4'd1; RDATA = 32'hD1; RLAST = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_rready", 64'(RREADY), 0);
      end
      @(posedge clk); #1;
      m_rready[1] = 1'b1;
      @(negedge clk);
      check("bp_rready_release", 64'(RREADY), 1);
      @(posedge clk); #1;
      RVALID = 1'b0;
      beat(4'd1, 32'hD2, 1'b0, 1);
      beat(4'd1, 32'hD3, 1'b1, 1);
      check("bp_errs", 64'({err_id, err_len}), 0);

      // Foreign RID during grant 2.
      set_req(2, 26'h0000400, 4'd2);
      wait_arready(2);
      beat(4'd2, 32'hE0, 1'b0, 2);
      RVALID = 1'b1; RID = 4'd1; RDATA = 32'hEE; RLAST = 1'b0;
      @(negedge clk);
      check("foreign_rready", 64'(RREADY), 1);
      check("foreign_m_rvalid", 64'(m_rvalid), 0);
      @(posedge clk); #1;
      RVALID = 1'b0;
      check("foreign_err_id", 64'(err_id), 1);
      beat(4'd2, 32'hE1, 1'b0, 2);
      beat(4'd2, 32'hE2, 1'b1, 2);
      check("foreign_err_len", 64'(err_len), 0);

      // Short burst: len 3, RLAST on 2nd beat.
      set_req(0, 26'h0000500, 4'd3);
      wait_arready(0);
      beat(4'd0, 32'hF0, 1'b0, 0);
      beat(4'd0, 32'hF1, 1'b1, 0);
      check("short_err_len", 64'(err_len), 1);
      check("short_busy", 64'(busy), 0);

      // Reset in the middle of a DATA phase.
      set_req(1, 26'h0ABCDE0, 4'd3);
      wait_arready(1);
      RVALID = 1'b1; RID = 4'd0; RDATA = 32'h55; RLAST = 1'b0;
      @(negedge clk);
      check("pre_rst_rready", 64'(RREADY), 1);
      check("pre_rst_busy", 64'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_arvalid", 64'(ARVALID), 0);
      check("mid_rst_rready", 64'(RREADY), 0);
      check("mid_rst_busy", 64'(busy), 0);
      check("mid_rst_errs", 64'({err_id, err_len}), 0);
      RVALID = 1'b0;
      #1 rst = 1'b0;
      @(posedge clk); #1;
      set_req(2, 26'h0000600, 4'd0);
      wait_arready(2);
      beat(4'd2, 32'h66, 1'b1, 2);

      repeat (3) @(posedge clk);
      check("arq_empty", 64'(arq.size()), 0);
      check("rq_empty", 64'(rq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
